// File: rtl/meas_window_sched.sv
// Round-robin scheduler sharing one event counter among NREQ requesters.
// Each grant runs a window of window_len cycles and reports the event count.
module meas_window_sched #(
  parameter int NREQ  = 4,
  parameter int CNT_W = 12,
  parameter int WIN_W = 16,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic [WIN_W-1:0] window_len,
  input  logic [NREQ-1:0]  event_in,
  output logic [NREQ-1:0]  grant,
  output logic             busy,
  output logic             result_valid,
  output logic [IDW-1:0]   result_id,
  output logic [CNT_W-1:0] result_count,
  output logic             result_sat
);

  typedef enum logic [1:0] {IDLE, ARM, COUNT, REPORT} state_t;

  state_t           state;
  state_t           state_next;
  logic [IDW-1:0]   sel;
  logic [IDW-1:0]   sel_inc;
  logic [IDW-1:0]   rr_ptr;
  logic [WIN_W-1:0] remaining;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             sat;
  logic             sat_next;
  logic             pick_found;
  logic [IDW-1:0]   pick_idx;

  assign sel_inc = (sel == IDW'(NREQ - 1)) ? '0 : sel + IDW'(1);

  // First set request at or above rr_ptr, wrapping modulo NREQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!pick_found && req[IDW'(idx)]) begin
        pick_found = 1'b1;
        pick_idx   = IDW'(idx);
      end
    end
  end

  always_comb begin
    cnt_next = cnt;
    sat_next = sat;
    if (event_in[sel]) begin
      if (cnt == '1) sat_next = 1'b1;
      else           cnt_next = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Dropping the owner's request aborts the window, even on its last cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick_found) state_next = ARM;
      ARM: begin
        if (!req[sel])               state_next = IDLE;
        else if (window_len == '0)   state_next = REPORT;
        else                         state_next = COUNT;
      end
      COUNT: begin
        if (!req[sel])                      state_next = IDLE;
        else if (remaining == WIN_W'(1))    state_next = REPORT;
      end
      REPORT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // Results are loaded on entry to REPORT so they are valid with the pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant        <= '0;
      sel          <= '0;
      rr_ptr       <= '0;
      remaining    <= '0;
      cnt          <= '0;
      sat          <= 1'b0;
      result_valid <= 1'b0;
      result_id    <= '0;
      result_count <= '0;
      result_sat   <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            sel   <= pick_idx;
            grant <= NREQ'(1) << pick_idx;
          end
        end
        ARM: begin
          remaining <= window_len;
          cnt       <= '0;
          sat       <= 1'b0;
        end
        COUNT: begin
          remaining <= remaining - WIN_W'(1);
          cnt       <= cnt_next;
          sat       <= sat_next;
        end
        REPORT:  rr_ptr <= sel_inc;
        default: ;
      endcase
      if (state == ARM || state == COUNT) begin
        if (state_next == IDLE) begin
          grant  <= '0;
          rr_ptr <= sel_inc;
        end else if (state_next == REPORT) begin
          grant        <= '0;
          result_valid <= 1'b1;
          result_id    <= sel;
          result_count <= (state == COUNT) ? cnt_next : '0;
          result_sat   <= (state == COUNT) ? sat_next : 1'b0;
        end
      end
    end
  end

endmodule
